// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU controller: ALU codes, funct/ALUOp encodings, mul/div sequencer state.
// No logic; latency and backpressure are defined by the modules that import it.
// Both the decoder and the sequencer take every encoding from here so they cannot drift apart.
package alu_ctrl_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLL = 4'b0011;
    localparam logic [3:0] CTRL_SRL = 4'b0100;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1010;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // The low two funct bits of 0x18..0x1B are exactly the md_op encoding.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_md_funct(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// Pure combinational ALUOp/funct decode to ALU code plus side-band flags for the sequencer.
// Zero latency; no state, no backpressure.
module alu_funct_dec
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 4
) (
    input  logic               valid,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [5:0]         funct,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               jr,
    output logic               shamt_sel,
    output logic               hilo_sel,
    output logic               illegal,
    output logic               md_req,
    output logic               hilo_rd,
    output logic [1:0]         md_op
);

    logic       rtype;
    logic [3:0] ctrl;

    assign rtype    = (alu_op == ALUOP_W'(ALUOP_RTYPE));
    assign alu_ctrl = CTRL_W'(ctrl);
    assign md_op    = funct[1:0];

    always_comb begin
        ctrl      = CTRL_ADD;
        jr        = 1'b0;
        shamt_sel = 1'b0;
        hilo_sel  = 1'b0;
        illegal   = 1'b0;
        md_req    = 1'b0;
        hilo_rd   = 1'b0;
        if (rtype) begin
            case (funct)
                FN_ADD: ctrl = CTRL_ADD;
                FN_SUB: ctrl = CTRL_SUB;
                FN_AND: ctrl = CTRL_AND;
                FN_OR:  ctrl = CTRL_OR;
                FN_NOR: ctrl = CTRL_NOR;
                FN_SLT: ctrl = CTRL_SLT;
                FN_SLL: begin
                    ctrl      = CTRL_SLL;
                    shamt_sel = 1'b1;
                end
                FN_SRL: begin
                    ctrl      = CTRL_SRL;
                    shamt_sel = 1'b1;
                end
                // JR computes nothing; the ADD code keeps the ALU in a benign state.
                FN_JR: jr = 1'b1;
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: md_req = 1'b1;
                FN_MFHI: begin
                    hilo_sel = 1'b1;
                    hilo_rd  = 1'b1;
                end
                FN_MFLO: hilo_rd = 1'b1;
                default: illegal = valid;
            endcase
        end else begin
            case (alu_op)
                ALUOP_W'(ALUOP_SUB): ctrl = CTRL_SUB;
                ALUOP_W'(ALUOP_OR):  ctrl = CTRL_OR;
                ALUOP_W'(ALUOP_AND): ctrl = CTRL_AND;
                ALUOP_W'(ALUOP_SLT): ctrl = CTRL_SLT;
                default:             ctrl = CTRL_ADD;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU controller: combinational ALU decode plus IDLE/BUSY/DONE sequencer for the iterative mul/div unit.
// Decode zero latency; md_start one cycle after accept, hilo_we CYCLES+1 after, ready again CYCLES+2 after.
// Backpressure: mul/div and MFHI/MFLO stall while not idle; other ALU ops flow past a busy unit.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [5:0]         funct_i,
    input  logic               flush_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               jr_o,
    output logic               shamt_sel_o,
    output logic               ready_o,
    output logic               md_start_o,
    output logic [1:0]         md_op_o,
    output logic               stall_o,
    output logic               hilo_we_o,
    output logic               hilo_sel_o,
    output logic               illegal_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       md_op_q, md_op_d;
    logic             md_start_q, md_start_d;
    logic             hilo_we_q, hilo_we_d;

    logic             md_req;
    logic             hilo_rd;
    logic [1:0]       md_op_dec;
    logic             accept;

    alu_funct_dec #(
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W)
    ) u_dec (
        .valid     (valid_i),
        .alu_op    (ALUOp_i),
        .funct     (funct_i),
        .alu_ctrl  (ALUCtrl_o),
        .jr        (jr_o),
        .shamt_sel (shamt_sel_o),
        .hilo_sel  (hilo_sel_o),
        .illegal   (illegal_o),
        .md_req    (md_req),
        .hilo_rd   (hilo_rd),
        .md_op     (md_op_dec)
    );

    assign ready_o    = (state == ST_IDLE);
    assign accept     = ready_o && valid_i && md_req;
    assign stall_o    = valid_i && !ready_o && (md_req || hilo_rd);
    assign md_start_o = md_start_q;
    assign md_op_o    = md_op_q;
    assign hilo_we_o  = hilo_we_q;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        md_op_d    = md_op_q;
        md_start_d = 1'b0;
        hilo_we_d  = 1'b0;
        // Flush wins over everything, including an accept in the same cycle.
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_d    = ST_BUSY;
                        cnt_d      = md_op_dec[1] ? DIV_LOAD : MUL_LOAD;
                        md_op_d    = md_op_dec;
                        md_start_d = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state_d   = ST_DONE;
                        hilo_we_d = 1'b1;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            md_op_q    <= MD_MULT;
            md_start_q <= 1'b0;
            hilo_we_q  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            md_op_q    <= md_op_d;
            md_start_q <= md_start_d;
            hilo_we_q  <= hilo_we_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized scoreboard bench for alu_ctrl_seq with a cycle-timeline reference model (MUL=4, DIV=6).
module tb_alu_ctrl_seq;

    localparam int MUL_C = 4;
    localparam int DIV_C = 6;
    localparam logic [2:0] RT = 3'b010;

    logic       clk_i;
    logic       rst_i;
    logic       valid_i;
    logic [2:0] ALUOp_i;
    logic [5:0] funct_i;
    logic       flush_i;
    logic [3:0] ALUCtrl_o;
    logic       jr_o, shamt_sel_o, ready_o, md_start_o, stall_o, hilo_we_o, hilo_sel_o, illegal_o;
    logic [1:0] md_op_o;

    alu_ctrl_seq #(
        .ALUOP_W    (3),
        .CTRL_W     (4),
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ALUOp_i     (ALUOp_i),
        .funct_i     (funct_i),
        .flush_i     (flush_i),
        .ALUCtrl_o   (ALUCtrl_o),
        .jr_o        (jr_o),
        .shamt_sel_o (shamt_sel_o),
        .ready_o     (ready_o),
        .md_start_o  (md_start_o),
        .md_op_o     (md_op_o),
        .stall_o     (stall_o),
        .hilo_we_o   (hilo_we_o),
        .hilo_sel_o  (hilo_sel_o),
        .illegal_o   (illegal_o)
    );

    typedef struct {
        int         cyc;
        logic       chk_reg;
        logic [3:0] ctrl;
        logic       jr, sh, hs, ill, ready, stall;
        logic [1:0] md_op;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       we;
        logic [1:0] op;
    } ev_t;

    exp_t dq[$];
    ev_t  evq[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: the unit is busy until busy_end (first cycle it is idle again).
    int         busy_end = 0;
    logic [1:0] op_model = 2'b00;
    logic       reg_valid = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    function automatic void ref_dec(input logic v, input logic [2:0] op, input logic [5:0] f,
                                    output logic [3:0] ctrl, output logic jr, output logic sh,
                                    output logic hs, output logic ill);
        ctrl = 4'b0010; jr = 1'b0; sh = 1'b0; hs = 1'b0; ill = 1'b0;
        if (op == RT) begin
            case (f)
                6'h20, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h12: ctrl = 4'b0010;
                6'h22: ctrl = 4'b0110;
                6'h24: ctrl = 4'b0000;
                6'h25: ctrl = 4'b0001;
                6'h27: ctrl = 4'b1010;
                6'h2A: ctrl = 4'b0111;
                6'h00: begin ctrl = 4'b0011; sh = 1'b1; end
                6'h02: begin ctrl = 4'b0100; sh = 1'b1; end
                6'h08: jr = 1'b1;
                6'h10: hs = 1'b1;
                default: ill = v;
            endcase
        end else begin
            case (op)
                3'b001: ctrl = 4'b0110;
                3'b011: ctrl = 4'b0001;
                3'b100: ctrl = 4'b0000;
                3'b101: ctrl = 4'b0111;
                default: ctrl = 4'b0010;
            endcase
        end
    endfunction

    task automatic step(input logic v, input logic [2:0] op, input logic [5:0] f,
                        input logic fl, input logic rn);
        exp_t e;
        ev_t  ev;
        logic md, hl;
        int   c, n;
        @(posedge clk_i);
        #1;
        c = cyc;
        valid_i = v; ALUOp_i = op; funct_i = f; flush_i = fl; rst_i = rn;
        ref_dec(v, op, f, e.ctrl, e.jr, e.sh, e.hs, e.ill);
        md = (op == RT) && (f >= 6'h18) && (f <= 6'h1B);
        hl = (op == RT) && (f == 6'h10 || f == 6'h12);
        e.cyc     = c;
        e.chk_reg = reg_valid;
        e.ready   = (c >= busy_end);
        e.stall   = v && !e.ready && (md || hl);
        e.md_op   = op_model;
        dq.push_back(e);
        if (!rn || fl) begin
            if (busy_end > c + 1) busy_end = c + 1;
            while (evq.size() > 0 && evq[$].cyc > c) void'(evq.pop_back());
            if (!rn) op_model = 2'b00;
        end else if (v && md && e.ready) begin
            n = f[1] ? DIV_C : MUL_C;
            busy_end = c + n + 2;
            ev.cyc = c + 1;     ev.we = 1'b0; ev.op = f[1:0]; evq.push_back(ev);
            ev.cyc = c + n + 1; ev.we = 1'b1; ev.op = f[1:0]; evq.push_back(ev);
            op_model = f[1:0];
        end
        if (!rn) reg_valid = 1'b1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 3'b000, 6'h00, 1'b0, 1'b1);
    endtask

    exp_t m_e;
    ev_t  m_ev;
    logic m_start, m_we;

    always @(negedge clk_i) begin
        if (dq.size() > 0) begin
            m_e = dq.pop_front();
            chk("alu_ctrl", 32'(ALUCtrl_o), 32'(m_e.ctrl), m_e.cyc);
            chk("jr", 32'(jr_o), 32'(m_e.jr), m_e.cyc);
            chk("shamt_sel", 32'(shamt_sel_o), 32'(m_e.sh), m_e.cyc);
            chk("hilo_sel", 32'(hilo_sel_o), 32'(m_e.hs), m_e.cyc);
            chk("illegal", 32'(illegal_o), 32'(m_e.ill), m_e.cyc);
            if (m_e.chk_reg) begin
                chk("ready", 32'(ready_o), 32'(m_e.ready), m_e.cyc);
                chk("stall", 32'(stall_o), 32'(m_e.stall), m_e.cyc);
                chk("md_op", 32'(md_op_o), 32'(m_e.md_op), m_e.cyc);
                m_start = 1'b0;
                m_we    = 1'b0;
                if (evq.size() > 0 && evq[0].cyc == m_e.cyc) begin
                    m_ev    = evq.pop_front();
                    m_start = !m_ev.we;
                    m_we    = m_ev.we;
                    chk("md_op_at_event", 32'(md_op_o), 32'(m_ev.op), m_e.cyc);
                end
                chk("md_start", 32'(md_start_o), 32'(m_start), m_e.cyc);
                chk("hilo_we", 32'(hilo_we_o), 32'(m_we), m_e.cyc);
            end
        end
    end

    logic [5:0] fn_tab [15];

    initial begin
        logic       v, fl, rn;
        logic [2:0] op;
        logic [5:0] f;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02,
                   6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12};
        valid_i = 1'b0; ALUOp_i = 3'b000; funct_i = 6'h00; flush_i = 1'b0; rst_i = 1'b0;
        step(1'b0, 3'b000, 6'h00, 1'b0, 1'b0);
        step(1'b0, 3'b000, 6'h00, 1'b0, 1'b0);
        idle(1);

        // Decode corner cases
        step(1'b1, RT, 6'h27, 1'b0, 1'b1);
        step(1'b1, RT, 6'h2A, 1'b0, 1'b1);
        step(1'b1, 3'b101, 6'h00, 1'b0, 1'b1);
        step(1'b1, RT, 6'h3F, 1'b0, 1'b1);
        step(1'b0, RT, 6'h3F, 1'b0, 1'b1);
        step(1'b1, RT, 6'h08, 1'b0, 1'b1);
        step(1'b1, RT, 6'h02, 1'b0, 1'b1);
        step(1'b1, 3'b111, 6'h22, 1'b0, 1'b1);

        // MULT, full run to idle
        step(1'b1, RT, 6'h18, 1'b0, 1'b1);
        idle(7);

        // DIVU then MFLO held while stalled
        step(1'b1, RT, 6'h1B, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 7; i++) step(1'b1, RT, 6'h12, 1'b0, 1'b1);
        idle(2);

        // MULT, ADD flows past, DIV held until accepted
        step(1'b1, RT, 6'h18, 1'b0, 1'b1);
        step(1'b1, RT, 6'h20, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, RT, 6'h1A, 1'b0, 1'b1);
        idle(10);

        // DIV flushed at cycle 3
        step(1'b1, RT, 6'h1A, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 3'b000, 6'h00, 1'b1, 1'b1);
        idle(9);

        // Flush in the same cycle as an accept
        step(1'b1, RT, 6'h19, 1'b1, 1'b1);
        idle(2);

        // MULT hit by reset at cycle 2
        step(1'b1, RT, 6'h18, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 3'b000, 6'h00, 1'b0, 1'b0);
        idle(7);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 1) == 0) ? RT : 3'($urandom_range(0, 7));
            f  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                               : fn_tab[$urandom_range(0, 14)];
            fl = ($urandom_range(0, 40) == 0);
            rn = ($urandom_range(0, 80) != 0);
            step(v, op, f, fl, rn);
        end
        idle(12);

        @(negedge clk_i);
        #1;
        chk("pending_events", 32'(evq.size()), 32'd0, cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
